// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; ops 0-10 finish one cycle after acceptance, result held until out_ready.
// Iterative mul/div/rem (XLEN or WLEN cycles in CALC) is built only with ALU_MC_MULDIV_EN defined.
module alu_mc #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic            alu_32,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            busy
);
  localparam int XSH = $clog2(XLEN);
  localparam int WSH = $clog2(WLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;

  logic [3:0]      r_op;
  logic            r_32;
  logic [XLEN-1:0] r_a, r_b;
  logic            w_accept, w_iter, w_last;
  logic [XLEN-1:0] w_fast, w_res, w_sum, w_sh_l, w_sh_r;
  logic signed [XLEN-1:0] w_sra_in, w_sh_a;
  logic [XLEN:0]   w_borrow;
  logic [XSH-1:0]  w_shamt;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = WLEN; i < XLEN; i++) y[i] = x[WLEN-1];
    return y;
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = WLEN; i < XLEN; i++) y[i] = 1'b0;
    return y;
  endfunction

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid & in_ready & ~kill;
  assign alu_result = out_valid ? w_res : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_32    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= alu_op;
        r_32 <= alu_32;
        r_a  <= alu_src1;
        r_b  <= alu_src2;
      end
    end
  end

  // kill wins over every other transition
  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next = w_iter ? S_CALC : S_DONE;
        S_CALC:  if (w_last) w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shamt  = r_32 ? XSH'(r_b[WSH-1:0]) : r_b[XSH-1:0];
    w_sum    = r_a + r_b;
    w_borrow = {1'b0, r_a} - {1'b0, r_b};
    w_sh_l   = r_a << w_shamt;
    w_sh_r   = (r_32 ? zext_w(r_a) : r_a) >> w_shamt;
    w_sra_in = r_32 ? sext_w(r_a) : r_a;
    w_sh_a   = w_sra_in >>> w_shamt;
    w_fast   = '0;
    case (r_op)
      4'd0:    w_fast = w_sum;
      4'd1:    w_fast = w_borrow[XLEN-1:0];
      4'd2:    w_fast = XLEN'((r_a[XLEN-1] != r_b[XLEN-1]) ? r_a[XLEN-1] : w_borrow[XLEN-1]);
      4'd3:    w_fast = XLEN'(w_borrow[XLEN]);
      4'd4:    w_fast = r_a & r_b;
      4'd5:    w_fast = r_a | r_b;
      4'd6:    w_fast = r_a ^ r_b;
      4'd7:    w_fast = w_sh_l;
      4'd8:    w_fast = w_sh_r;
      4'd9:    w_fast = w_sh_a;
      4'd10:   w_fast = r_b;
      default: w_fast = '0;
    endcase
    if (r_32 && (r_op <= 4'd1 || (r_op >= 4'd7 && r_op <= 4'd9))) w_fast = sext_w(w_fast);
  end

`ifdef ALU_MC_MULDIV_EN
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc, r_x, r_y;
  logic            r_neg_q, r_neg_r, r_div0;
  logic            w_sgn, w_n1, w_n2, w_top, w_ge;
  logic [XLEN-1:0] w_s1, w_s2, w_m1, w_m2, w_rsub, w_q, w_r, w_md;
  logic [XLEN:0]   w_rsh;

  assign w_iter = (alu_op >= 4'd11);
  assign w_last = (r_cnt == (r_32 ? CW'(WLEN-1) : CW'(XLEN-1)));
  assign busy   = (r_state == S_CALC);
  assign w_res  = (r_op >= 4'd11) ? w_md : w_fast;

  // signed div/rem run on magnitudes; r_y shifts dividend bits out and quotient bits in
  always_comb begin
    w_sgn  = (alu_op == 4'd12) || (alu_op == 4'd14);
    w_s1   = alu_32 ? (w_sgn ? sext_w(alu_src1) : zext_w(alu_src1)) : alu_src1;
    w_s2   = alu_32 ? (w_sgn ? sext_w(alu_src2) : zext_w(alu_src2)) : alu_src2;
    w_n1   = w_sgn & w_s1[XLEN-1];
    w_n2   = w_sgn & w_s2[XLEN-1];
    w_m1   = w_n1 ? -w_s1 : w_s1;
    w_m2   = w_n2 ? -w_s2 : w_s2;
    w_top  = r_32 ? r_y[WLEN-1] : r_y[XLEN-1];
    w_rsh  = {r_acc, w_top};
    w_ge   = (w_rsh >= {1'b0, r_x});
    w_rsub = w_rsh[XLEN-1:0] - r_x;
    w_q    = r_neg_q ? -r_y : r_y;
    w_r    = r_neg_r ? -r_acc : r_acc;
    case (r_op)
      4'd11:        w_md = r_acc;
      4'd12, 4'd13: w_md = r_div0 ? '1 : w_q;
      default:      w_md = r_div0 ? r_a : w_r;
    endcase
    if (r_32) w_md = sext_w(w_md);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_x     <= (alu_op == 4'd11) ? w_s1 : w_m2;
      r_y     <= (alu_op == 4'd11) ? w_s2 : w_m1;
      r_neg_q <= w_n1 ^ w_n2;
      r_neg_r <= w_n1;
      r_div0  <= (w_s2 == '0);
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_op == 4'd11) begin
        if (r_y[0]) r_acc <= r_acc + r_x;
        r_x <= r_x << 1;
        r_y <= r_y >> 1;
      end else begin
        r_acc <= w_ge ? w_rsub : w_rsh[XLEN-1:0];
        r_y   <= {r_y[XLEN-2:0], w_ge};
      end
    end
  end
`else
  assign w_iter = 1'b0;
  assign w_last = 1'b1;
  assign busy   = 1'b0;
  assign w_res  = w_fast;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Randomized scoreboard bench for alu_mc (XLEN=64, WLEN=32) plus directed corner cases.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, alu_32, kill, out_valid, out_ready, busy;
  logic [3:0]  alu_op;
  logic [63:0] alu_src1, alu_src2, alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 0;
  bit mon_off = 1'b0;
  bit busy_seen = 1'b0;

  typedef struct {
    logic [63:0] res;
    int          vcyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  alu_mc #(.XLEN(64), .WLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_32(alu_32), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model straight from the operation definitions.
  function automatic logic [63:0] model(input logic [3:0] op, input bit w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32;
    logic [63:0] r, q;
    longint sa, sb, mn;
    longint unsigned ua, ub;
    a32 = a[31:0];
    b32 = b[31:0];
    r = '0;
    if (op >= 4'd11) begin
`ifdef ALU_MC_MULDIV_EN
      if (w) begin
        sa = longint'($signed(a32)); sb = longint'($signed(b32));
        ua = {32'd0, a32};           ub = {32'd0, b32};
        mn = longint'($signed(32'h8000_0000));
      end else begin
        sa = a; sb = b; ua = a; ub = b;
        mn = 64'h8000_0000_0000_0000;
      end
      case (op)
        4'd11:   q = w ? {32'd0, a32 * b32} : a * b;
        4'd12:   q = (sb == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (sa == mn && sb == -1) ? sa : sa / sb;
        4'd13:   q = (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ua / ub;
        4'd14:   q = (sb == 0) ? sa : (sa == mn && sb == -1) ? 64'd0 : sa % sb;
        default: q = (ub == 0) ? ua : ua % ub;
      endcase
      r = w ? sx32(q[31:0]) : q;
`else
      r = '0;
`endif
    end else begin
      case (op)
        4'd0:    r = w ? sx32(a32 + b32) : a + b;
        4'd1:    r = w ? sx32(a32 - b32) : a - b;
        4'd2:    r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        4'd3:    r = (a < b) ? 64'd1 : 64'd0;
        4'd4:    r = a & b;
        4'd5:    r = a | b;
        4'd6:    r = a ^ b;
        4'd7:    r = w ? sx32(a32 << b[4:0]) : a << b[5:0];
        4'd8:    r = w ? sx32(a32 >> b[4:0]) : a >> b[5:0];
        4'd9:    r = w ? sx32($signed(a32) >>> b[4:0]) : $signed(a) >>> b[5:0];
        default: r = b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 70));
      4:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
      5:       return {32'($urandom), 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input bit sb);
    int t;
    int lat;
    exp_t x;
    t = 0;
    lat = 0;
`ifdef ALU_MC_MULDIV_EN
    if (op >= 4'd11) lat = w ? 32 : 64;
`endif
    alu_op = op; alu_32 = w; alu_src1 = a; alu_src2 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end else if (sb) begin
      x.res = e; x.vcyc = cyc + 1 + lat; x.lat = lat;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: latency, busy length, stability while stalled, result on handshake.
  bit          prev_vld = 1'b0;
  logic [63:0] held = '0;
  int          busy_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        busy_seen = 1'b1;
      end
      if (out_valid) check("ready_in_done", 64'(in_ready), 64'd0);
      if (!mon_off) begin
        if (out_valid && !prev_vld) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(out_valid), 64'd0);
          end else begin
            check("latency", 64'(cyc), 64'(exp_q[0].vcyc));
            check("busy_cycles", 64'(busy_cnt), 64'(exp_q[0].lat));
          end
        end
        if (out_valid && prev_vld) check("stable", alu_result, held);
        if (out_valid && out_ready && !kill && exp_q.size() > 0) begin
          check("result", alu_result, exp_q[0].res);
          void'(exp_q.pop_front());
        end
      end
      if (in_ready) busy_cnt = 0;
      prev_vld = out_valid;
      held = alu_result;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    bit          w;
    logic [63:0] a, b;
    bit          seen;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; alu_op = '0; alu_32 = 1'b0;
    alu_src1 = '0; alu_src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", alu_result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    issue(4'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b1);
    issue(4'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    issue(4'd9, 1'b0, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b1);
`ifdef ALU_MC_MULDIV_EN
    issue(4'd12, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    issue(4'd14, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(4'd13, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(4'd14, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1);
    issue(4'd12, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
    issue(4'd14, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(4'd11, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 1'b1);
`else
    issue(4'd11, 1'b0, 64'd3, 64'd4, 64'd0, 1'b1);
`endif
    drain();

    // result held while the consumer stalls
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    issue(4'd6, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_valid", 64'(out_valid), 64'd1);
    rdy_mode = 0;
    drain();

    for (int i = 0; i < 160; i++) begin
      op = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      a  = rnd();
      b  = rnd();
      if (i == 80) rdy_mode = 1;
      issue(op, w, a, b, model(op, w, a, b), 1'b1);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    mon_off = 1'b1;
`ifdef ALU_MC_MULDIV_EN
    issue(4'd12, 1'b0, 64'd100, 64'd7, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_calc_idle", 64'(in_ready), 64'd1);
    check("kill_calc_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("kill_calc_discard", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
`endif
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    issue(4'd0, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0);
    check("kill_done_pre", 64'(out_valid), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_done_valid", 64'(out_valid), 64'd0);
    check("kill_done_idle", 64'(in_ready), 64'd1);

    // reset while an operation is in flight
`ifdef ALU_MC_MULDIV_EN
    rdy_mode = 0;
    issue(4'd12, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
`else
    issue(4'd0, 1'b0, 64'd7, 64'd8, 64'd0, 1'b0);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", alu_result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_off = 1'b0;
    issue(4'd0, 1'b0, 64'd5, 64'd6, 64'd11, 1'b1);
`ifdef ALU_MC_MULDIV_EN
    issue(4'd12, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
`endif
    drain();

`ifndef ALU_MC_MULDIV_EN
    check("busy_never", 64'(busy_seen), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter WLEN, default 32, word-mode width; WLEN < XLEN when XLEN=64.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port alu_op  input  4  operation code: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 pass (src2), 11 mul, 12 div, 13 divu, 14 rem, 15 remu.
REQ-008 SHALL have port alu_32  input  1  word-mode operation.
REQ-009 SHALL have port alu_src1  input  XLEN  first operand.
REQ-010 SHALL have port alu_src2  input  XLEN  second operand / shift amount.
REQ-011 SHALL have port kill  input  1  abort current operation.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port alu_result  output  XLEN  result.
REQ-015 SHALL have port busy  output  1  high in CALC state.

Function
REQ-016 SHALL implement states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-017 SHALL accept a request on in_valid&in_ready, capturing alu_op, alu_32 and both operands into internal registers.
REQ-018 SHALL complete ops 0-10 in one cycle: IDLE -> DONE, out_valid asserted the cycle after acceptance.
REQ-019 SHALL run ops 11-15 iteratively: IDLE -> CALC for N cycles -> DONE, N=XLEN normally and N=WLEN when alu_32; busy high throughout CALC.
REQ-020 SHALL hold alu_result and out_valid stable in DONE until out_valid&out_ready, then go to IDLE; a new request is not accepted in the same cycle as a result handshake.
REQ-021 SHALL, on kill in any state, go to IDLE next cycle with out_valid=0 and discard the result; kill has priority over in_valid and out_ready.
REQ-022 SHALL compute slt as a correct signed compare (sign difference or sign of src1-src2 when signs equal); sltu as the unsigned borrow; both zero-extended 0/1.
REQ-023 SHALL use shift amount src2[log2(XLEN)-1:0], or src2[log2(WLEN)-1:0] when alu_32.
REQ-024 SHALL, when alu_32, operate on bits [WLEN-1:0] of the operands (sra/div/rem sign taken from bit WLEN-1) and sign-extend bit WLEN-1 of the result to XLEN; slt/sltu/and/or/xor/pass ignore alu_32.
REQ-025 SHALL return the low N bits of the product for mul.
REQ-026 SHALL, on divide by zero, return quotient all-ones and remainder = dividend (both at operation width N).
REQ-027 SHALL, on signed overflow (most-negative / -1), return quotient = dividend and remainder 0.
REQ-028 SHALL compute signed div/rem by magnitude division with sign fix-up: quotient negative iff operand signs differ, remainder takes dividend's sign.

Reset
REQ-029 SHALL, on rst, immediately enter IDLE with in_ready=1, out_valid=0, busy=0, alu_result=0, iteration counter=0, regardless of state.
REQ-030 SHALL, on rst released mid-CALC, leave no residual state; the next accepted request computes correctly.

Configuration
REQ-031 SHALL compile the iterative mul/div/rem unit only when macro ALU_MC_MULDIV_EN is defined.
REQ-032 SHALL, with ALU_MC_MULDIV_EN undefined, treat ops 11-15 as one-cycle ops returning 0 and never enter CALC (busy tied 0).

Verification
REQ-033 SHALL verify: XLEN=64, add src1=0x7FFF_FFFF, src2=1, alu_32=1 -> out_valid next cycle, result 0xFFFF_FFFF_8000_0000.
REQ-034 SHALL verify: slt src1=-1, src2=1 -> 1; sltu same operands -> 0; sra src1=0x8000_0000_0000_0000, src2=0x43 -> 0xF000_0000_0000_0000.
REQ-035 SHALL verify: div src1=-7, src2=2 -> -3 after 64 CALC cycles; rem same operands -> -1; divu src1=5, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF; rem 5 by 0 -> 5.
REQ-036 SHALL verify: div src1=0x8000_0000_0000_0000, src2=-1 -> 0x8000_0000_0000_0000, rem -> 0; mul alu_32=1 src1=0x10000, src2=0x10000 -> 0 after 32 cycles.
REQ-037 SHALL verify: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable; kill at CALC cycle 10 -> IDLE next cycle, no out_valid; rst asserted mid-CALC -> IDLE, outputs at reset values, next add correct.
REQ-038 SHALL verify: build without ALU_MC_MULDIV_EN, mul 3x4 -> result 0 one cycle after acceptance, busy never 1.
